alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Multi-cycle controller that accepts RV32I R-type instructions over a valid/ready handshake and sequences the register-file/ALU datapath.
- Decodes each instruction into datapath controls: read_reg_1, read_reg_2, write_reg, ALUControl, write_enable.
- Captures the datapath Zero flag and reports completion or an illegal instruction to the upstream fetch logic.
- Sits between instruction source and datapath; sole driver of datapath control inputs.

Parameters:
- REG_ADDR_W, 5, register index width (32 architectural registers).
- CNT_W, 32, retire-counter width (used only when the optional feature is compiled in).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  instruction word; sampled on handshake.
- instr_valid  in  1  upstream has an instruction.
- instr_ready  out  1  sequencer can accept an instruction.
- read_reg_1  out  REG_ADDR_W  rs1 to datapath.
- read_reg_2  out  REG_ADDR_W  rs2 to datapath.
- write_reg  out  REG_ADDR_W  rd to datapath.
- ALUControl  out  4  ALU operation select.
- write_enable  out  1  register-file write strobe.
- Zero  in  1  ALU zero flag from datapath.
- done  out  1  one-cycle pulse: instruction retired.
- illegal  out  1  one-cycle pulse: instruction rejected.
- zero_flag  out  1  Zero captured at the last writeback cycle.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock, clk; reset is asynchronous, active-low.
- Reset value of every output: all outputs 0 except instr_ready = 1. State goes to IDLE immediately, without waiting for a clock edge.
- Reset mid-operation:
  - The in-flight instruction is dropped.
  - write_enable drops at once.
  - No partial write, done or illegal pulse.
- FSM states: IDLE, EXEC, DONE, ILL. All outputs are registered (Moore).
- IDLE:
  - instr_ready = 1.
  - On instr_valid && instr_ready, latch instr into IR and decode.
  - Legal instruction -> EXEC. Illegal instruction -> ILL.
- Legal instruction: opcode 7'b0110011 with one of these funct7/funct3 pairs:
  - ADD 0000000/000; SUB 0100000/000
  - SLL 0000000/001; SLT 0000000/010; SLTU 0000000/011
  - XOR 0000000/100; SRL 0000000/101; SRA 0100000/101
  - OR 0000000/110; AND 0000000/111
  - Anything else is illegal.
- EXEC (exactly 1 cycle):
  - read_reg_1 = IR[19:15], read_reg_2 = IR[24:20], write_reg = IR[11:7], ALUControl = decoded code.
  - write_enable = 1 unless rd == 0. For rd == 0 the op executes but no write occurs.
  - At the closing edge, Zero is captured into zero_flag. Next state DONE.
- DONE (1 cycle): done = 1, write_enable = 0, control fields hold. Next state IDLE.
- ILL (1 cycle): illegal = 1, no write. zero_flag and the control fields keep their previous values. Next state IDLE.
- Latency and throughput: handshake edge -> write at +1 edge -> done visible 2 cycles after handshake. Throughput is one instruction per 3 cycles.
- Handshake rules:
  - instr_ready is low in EXEC, DONE and ILL.
  - instr is ignored when not handshaking.
  - instr_valid held high while not ready is legal; the instruction is taken on return to IDLE.
- busy = (state != IDLE).
- ALUControl encoding (fixed, matches the team ALU): AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111, SRA 1000, SLTU 1001.

Optional Feature:
- Macro: ALU_SEQ_RETIRE_CNT_EN.
- With the macro: adds output retire_count [CNT_W-1:0].
  - Increments once per done pulse and wraps modulo 2^CNT_W.
  - Illegal instructions are not counted.
  - Resets to 0.
- Without the macro: port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the ALUControl localparams listed above;
  - OPCODE_OP = 7'b0110011;
  - the funct7 constants F7_BASE = 7'b0000000 and F7_ALT = 7'b0100000;
  - the FSM state enum.
- One natural sub-module: alu_op_decode, combinational.
  - Input: instr. Outputs: ALUControl, legal.
  - Keeps decode separate from the FSM.

Test Plan:
- Reset: assert reset=0 mid-EXEC with write_enable=1 -> write_enable=0 immediately; instr_ready=1; no done pulse after release.
- ADD x3,x1,x2 (instr 32'h002081B3), x1=5, x2=7: handshake -> next cycle write_enable=1, read_reg_1=1, read_reg_2=2, write_reg=3, ALUControl=0010 -> next cycle done=1; x3 reads 12; zero_flag=0.
- SUB x4,x1,x1 (32'h40108233), x1=9 -> ALUControl=0110; x4=0; zero_flag=1 after done.
- Write to x0: ADD x0,x1,x2 -> write_enable stays 0 throughout; done=1; x0 unchanged.
- Illegal: instr 32'h00000013 (ADDI) and funct7=0100000/funct3=111 -> illegal pulses 1 cycle, no write_enable, returns to IDLE in 2 cycles.
- Back-to-back: instr_valid held high with 4 legal instructions -> instr_ready pattern 1,0,0 repeating; 4 done pulses; retire_count=4 when ALU_SEQ_RETIRE_CNT_EN is defined.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU op sequencer: ALU operation codes, RV32I OP-class
// decode constants and the sequencer FSM state type.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone,
    StIll
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of an RV32I R-type instruction into an ALU operation code
// plus a legality flag; anything outside the supported OP-class set is illegal.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  ALUControl,
  output logic        legal
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register fields are routed by the sequencer, not needed for decode.
  logic unused_fields;
  assign unused_fields = ^instr[24:15] ^ ^instr[11:7];

  always_comb begin
    ALUControl = ALU_AND;
    legal      = 1'b0;
    if (opcode == OPCODE_OP) begin
      case ({funct7, funct3})
        {F7_BASE, 3'b000}: begin ALUControl = ALU_ADD;  legal = 1'b1; end
        {F7_ALT,  3'b000}: begin ALUControl = ALU_SUB;  legal = 1'b1; end
        {F7_BASE, 3'b001}: begin ALUControl = ALU_SLL;  legal = 1'b1; end
        {F7_BASE, 3'b010}: begin ALUControl = ALU_SLT;  legal = 1'b1; end
        {F7_BASE, 3'b011}: begin ALUControl = ALU_SLTU; legal = 1'b1; end
        {F7_BASE, 3'b100}: begin ALUControl = ALU_XOR;  legal = 1'b1; end
        {F7_BASE, 3'b101}: begin ALUControl = ALU_SRL;  legal = 1'b1; end
        {F7_ALT,  3'b101}: begin ALUControl = ALU_SRA;  legal = 1'b1; end
        {F7_BASE, 3'b110}: begin ALUControl = ALU_OR;   legal = 1'b1; end
        {F7_BASE, 3'b111}: begin ALUControl = ALU_AND;  legal = 1'b1; end
        default: begin
          ALUControl = ALU_AND;
          legal      = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle R-type sequencer driving the register-file/ALU datapath controls.
// Optional retire counter output enabled with `define ALU_SEQ_RETIRE_CNT_EN.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  output logic [REG_ADDR_W-1:0] read_reg_1,
  output logic [REG_ADDR_W-1:0] read_reg_2,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic [3:0]            ALUControl,
  output logic                  write_enable,
  input  logic                  Zero,
  output logic                  done,
  output logic                  illegal,
  output logic                  zero_flag,
  output logic                  busy
`ifdef ALU_SEQ_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]      retire_count
`endif
);

  logic [3:0] dec_alu;
  logic       dec_legal;
  state_e     state_q;

  alu_op_decode u_decode (
    .instr      (instr),
    .ALUControl (dec_alu),
    .legal      (dec_legal)
  );

  // Moore FSM: every output is a register updated on the transition into the
  // state where it must be visible.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      instr_ready  <= 1'b1;
      read_reg_1   <= '0;
      read_reg_2   <= '0;
      write_reg    <= '0;
      ALUControl   <= '0;
      write_enable <= 1'b0;
      done         <= 1'b0;
      illegal      <= 1'b0;
      zero_flag    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      done    <= 1'b0;
      illegal <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            instr_ready <= 1'b0;
            busy        <= 1'b1;
            if (dec_legal) begin
              state_q      <= StExec;
              read_reg_1   <= REG_ADDR_W'(instr[19:15]);
              read_reg_2   <= REG_ADDR_W'(instr[24:20]);
              write_reg    <= REG_ADDR_W'(instr[11:7]);
              ALUControl   <= dec_alu;
              // x0 is hardwired: the op still runs but nothing is written.
              write_enable <= |instr[11:7];
            end else begin
              state_q <= StIll;
              illegal <= 1'b1;
            end
          end
        end
        StExec: begin
          state_q      <= StDone;
          zero_flag    <= Zero;
          write_enable <= 1'b0;
          done         <= 1'b1;
        end
        StDone, StIll: begin
          state_q     <= StIdle;
          instr_ready <= 1'b1;
          busy        <= 1'b0;
        end
        default: begin
          state_q      <= StIdle;
          instr_ready  <= 1'b1;
          busy         <= 1'b0;
          write_enable <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_RETIRE_CNT_EN
  // Bumps on the same edge that raises done, so the count tracks the pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_count <= '0;
    end else if (state_q == StExec) begin
      retire_count <= retire_count + 1'b1;
    end
  end
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer with a small register-file/ALU datapath
// and an instruction-level reference model.
module tb_alu_op_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  read_reg_1, read_reg_2, write_reg;
  logic [3:0]  ALUControl;
  logic        write_enable;
  logic        Zero;
  logic        done, illegal, zero_flag, busy;
`ifdef ALU_SEQ_RETIRE_CNT_EN
  logic [31:0] retire_count;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  alu_op_sequencer #(.REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .read_reg_1   (read_reg_1),
    .read_reg_2   (read_reg_2),
    .write_reg    (write_reg),
    .ALUControl   (ALUControl),
    .write_enable (write_enable),
    .Zero         (Zero),
    .done         (done),
    .illegal      (illegal),
    .zero_flag    (zero_flag),
    .busy         (busy)
`ifdef ALU_SEQ_RETIRE_CNT_EN
    ,
    .retire_count (retire_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath stand-in: register file plus team ALU, driven purely by DUT controls.
  logic [31:0] rf [32];
  logic [31:0] dp_a, dp_b, dp_y;
  logic        pre_we;
  logic [4:0]  pre_idx;
  logic [31:0] pre_val;

  always_comb begin
    dp_a = rf[read_reg_1];
    dp_b = rf[read_reg_2];
    dp_y = 32'h0;
    case (ALUControl)
      4'b0000: dp_y = dp_a & dp_b;
      4'b0001: dp_y = dp_a | dp_b;
      4'b0010: dp_y = dp_a + dp_b;
      4'b0011: dp_y = dp_a ^ dp_b;
      4'b0100: dp_y = dp_a << dp_b[4:0];
      4'b0101: dp_y = dp_a >> dp_b[4:0];
      4'b0110: dp_y = dp_a - dp_b;
      4'b0111: dp_y = {31'b0, $signed(dp_a) < $signed(dp_b)};
      4'b1000: dp_y = $unsigned($signed(dp_a) >>> dp_b[4:0]);
      4'b1001: dp_y = {31'b0, dp_a < dp_b};
      default: dp_y = 32'h0;
    endcase
    Zero = (dp_y == 32'h0);
  end

  always @(posedge clk) begin
    if (pre_we) rf[pre_idx] <= pre_val;
    else if (write_enable) rf[write_reg] <= dp_y;
  end

  int done_cnt = 0;
  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  // Reference state: architectural registers and last-visible control fields.
  logic [31:0] ref_rf [32];
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [3:0]  e_alu;
  logic        e_zf;
  int          retire_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [6:0] f7, input logic [4:0] rs2,
                                      input logic [4:0] rs1, input logic [2:0] f3,
                                      input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  // Instruction semantics by mnemonic; code is the ALU select the team ALU expects.
  function automatic void ref_op(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] b, output logic ok,
                                 output logic [31:0] y, output logic [3:0] code);
    ok = 1'b1; y = 32'h0; code = 4'h0;
    if (ins[6:0] != 7'b0110011) ok = 1'b0;
    else begin
      case ({ins[31:25], ins[14:12]})
        {7'h00, 3'd0}: begin y = a + b;                  code = 4'b0010; end // ADD
        {7'h20, 3'd0}: begin y = a - b;                  code = 4'b0110; end // SUB
        {7'h00, 3'd1}: begin y = a << b[4:0];            code = 4'b0100; end // SLL
        {7'h00, 3'd2}: begin y = ($signed(a) < $signed(b)) ? 1 : 0; code = 4'b0111; end
        {7'h00, 3'd3}: begin y = (a < b) ? 1 : 0;        code = 4'b1001; end // SLTU
        {7'h00, 3'd4}: begin y = a ^ b;                  code = 4'b0011; end // XOR
        {7'h00, 3'd5}: begin y = a >> b[4:0];            code = 4'b0101; end // SRL
        {7'h20, 3'd5}: begin y = $unsigned($signed(a) >>> b[4:0]); code = 4'b1000; end
        {7'h00, 3'd6}: begin y = a | b;                  code = 4'b0001; end // OR
        {7'h00, 3'd7}: begin y = a & b;                  code = 4'b0000; end // AND
        default: ok = 1'b0;
      endcase
    end
    if (!ok) begin y = 32'h0; code = 4'h0; end
  endfunction

  task automatic set_reg(input logic [4:0] idx, input logic [31:0] val);
    pre_we = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
    ref_rf[idx] = val;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (instr_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check({tag, ":ready"}, instr_ready, 1);
  endtask

  task automatic expect_reset_state(input string tag);
    check({tag, ":instr_ready"}, instr_ready, 1);
    check({tag, ":busy"}, busy, 0);
    check({tag, ":write_enable"}, write_enable, 0);
    check({tag, ":fields"}, {read_reg_1, read_reg_2, write_reg, ALUControl}, 0);
    check({tag, ":pulses_zf"}, {done, illegal, zero_flag}, 0);
    e_rs1 = 0; e_rs2 = 0; e_rd = 0; e_alu = 0; e_zf = 0; retire_exp = 0;
  endtask

  task automatic run_one(input logic [31:0] ins, input string tag);
    logic ok;
    logic [31:0] y;
    logic [3:0] code;
    logic [4:0] rs1, rs2, rd;
    rs1 = ins[19:15]; rs2 = ins[24:20]; rd = ins[11:7];
    wait_ready(tag);
    ref_op(ins, ref_rf[rs1], ref_rf[rs2], ok, y, code);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = $urandom;
    check({tag, ":busy_ready"}, {busy, instr_ready}, 2'b10);
    if (ok) begin
      check({tag, ":we_exec"}, write_enable, (rd != 0));
      check({tag, ":fields"}, {read_reg_1, read_reg_2, write_reg}, {rs1, rs2, rd});
      check({tag, ":alu"}, ALUControl, code);
      check({tag, ":no_pulse"}, {done, illegal}, 0);
      @(posedge clk); #1;
      check({tag, ":done"}, done, 1);
      check({tag, ":we_done"}, write_enable, 0);
      check({tag, ":zero_flag"}, zero_flag, (y == 0));
      check({tag, ":hold_rd"}, write_reg, rd);
      if (rd != 0) ref_rf[rd] = y;
      check({tag, ":rf_rd"}, rf[rd], ref_rf[rd]);
      e_rs1 = rs1; e_rs2 = rs2; e_rd = rd; e_alu = code; e_zf = (y == 0);
      retire_exp++;
      @(posedge clk); #1;
      check({tag, ":idle"}, {done, instr_ready, busy}, 3'b010);
    end else begin
      check({tag, ":illegal"}, illegal, 1);
      check({tag, ":we_ill"}, write_enable, 0);
      check({tag, ":ill_hold"}, {read_reg_1, read_reg_2, write_reg, ALUControl, zero_flag},
            {e_rs1, e_rs2, e_rd, e_alu, e_zf});
      @(posedge clk); #1;
      check({tag, ":ill_end"}, {illegal, instr_ready, busy, done}, 4'b0100);
    end
  endtask

  logic [6:0] lf7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20,
                           7'h00, 7'h00};
  logic [2:0] lf3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};

  function automatic logic [31:0] rand_legal();
    int k;
    logic [4:0] rs1;
    logic [4:0] rs2;
    k = $urandom_range(0, 9);
    rs1 = 5'($urandom);
    rs2 = ($urandom_range(0, 3) == 0) ? rs1 : 5'($urandom);
    return enc(lf7[k], rs2, rs1, lf3[k], 5'($urandom));
  endfunction

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ins;
    logic [31:0] b2b [4];
    int d0;
    reset = 1'b0; instr = 32'h0; instr_valid = 1'b0;
    pre_we = 1'b0; pre_idx = 0; pre_val = 0;
    #12;
    expect_reset_state("reset");
    reset = 1'b1;
    @(posedge clk); #1;
    set_reg(0, 0);
    for (int i = 1; i < 32; i++) set_reg(5'(i), $urandom);

    set_reg(1, 5); set_reg(2, 7);
    run_one(32'h002081B3, "add_x3");
    check("add_x3_val", rf[3], 12);
    set_reg(1, 9);
    run_one(32'h40108233, "sub_x4");
    check("sub_x4_zf", {rf[4], zero_flag}, {32'h0, 1'b1});
    run_one(enc(7'h00, 5'd2, 5'd1, 3'd0, 5'd0), "add_x0");
    check("x0_unchanged", rf[0], 0);
    run_one(32'h00000013, "ill_addi");
    run_one(enc(7'h20, 5'd2, 5'd1, 3'd7, 5'd4), "ill_f7alt_and");

    // Reset landing in the middle of EXEC.
    wait_ready("rst_mid");
    d0 = done_cnt;
    instr = 32'h002082B3; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    check("rst_mid:we_exec", write_enable, 1);
    #2 reset = 1'b0;
    #1;
    expect_reset_state("rst_mid_async");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin @(posedge clk); #1; end
    check("rst_mid:no_done", done_cnt - d0, 0);
    check("rst_mid:no_write", rf[5], ref_rf[5]);

    for (int i = 0; i < 24; i++) begin
      int r = $urandom_range(0, 9);
      if (r < 7) ins = rand_legal();
      else begin
        ins = enc(($urandom_range(0, 1) != 0) ? 7'h20 : 7'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 5'($urandom));
        if (r == 9) ins[6:0] = 7'($urandom);
      end
      run_one(ins, $sformatf("rnd%0d", i));
    end

    // Back-to-back with instr_valid held high.
    for (int k = 0; k < 4; k++) begin
      b2b[k] = rand_legal();
      if (b2b[k][11:7] == 0) b2b[k][11:7] = 5'd9;
    end
    wait_ready("b2b");
    d0 = done_cnt;
    instr = b2b[0]; instr_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic ok;
      logic [31:0] y;
      logic [3:0] code;
      ref_op(b2b[k], ref_rf[b2b[k][19:15]], ref_rf[b2b[k][24:20]], ok, y, code);
      check($sformatf("b2b%0d:ready1", k), instr_ready, 1);
      @(posedge clk); #1;
      instr = (k < 3) ? b2b[k+1] : 32'h0;
      if (k == 3) instr_valid = 1'b0;
      check($sformatf("b2b%0d:ready_exec", k), {instr_ready, ALUControl}, {1'b0, code});
      @(posedge clk); #1;
      check($sformatf("b2b%0d:ready_done", k), {instr_ready, done}, 2'b01);
      ref_rf[b2b[k][11:7]] = y;
      check($sformatf("b2b%0d:rf", k), rf[b2b[k][11:7]], y);
      retire_exp++;
      @(posedge clk); #1;
    end
    check("b2b:done_pulses", done_cnt - d0, 4);
`ifdef ALU_SEQ_RETIRE_CNT_EN
    check("retire_count", retire_count, retire_exp);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
